// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Lane slicing keeps flattened per-port buses consistent between top and bench.
package regfile_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

  // Low bit of lane `lane` in a flattened bus of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Control-side bus of the register file: write, reservation, read lanes, clear.
// The control unit holds the master modport; regfile_mp holds the slave.
interface regfile_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NRD    = 2
);
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    rsv_en;
  logic [ADDR_W-1:0]       rsv_addr;
  logic [NRD-1:0]          rd_en;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*DATA_W-1:0]   rd_data;
  logic [NRD-1:0]          rd_pend;
  logic [NRD-1:0]          rd_valid;
  logic                    clr_start;
  logic                    clr_busy;
  logic                    clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_en, rd_addr, clr_start,
    input  rd_data, rd_pend, rd_valid, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_en, rd_addr, clr_start,
    output rd_data, rd_pend, rd_valid, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_rdport.sv
// One read lane: range/zero-register check, write forwarding, registered outputs.
// Write/reservation qualifiers arrive already filtered (range, zero reg, clear).
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         i_rd_en,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_mem,
  input  logic [DEPTH-1:0]             i_pend,
  input  logic                         i_wr_ok,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_rsv_ok,
  input  logic [ADDR_W-1:0]            i_rsv_addr,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_rd_pend,
  output logic                         o_rd_valid
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              w_in_rng;
  logic              w_zero;
  logic              w_fwd;
  logic [ADDR_W-1:0] w_idx;
  logic [DATA_W-1:0] w_data;
  logic              w_pend;

  assign w_in_rng = ({1'b0, i_rd_addr} < DEPTH_L);
  assign w_zero   = (ZERO_REG != 0) && (i_rd_addr == '0);
  assign w_idx    = w_in_rng ? i_rd_addr : '0;
  assign w_fwd    = (BYPASS != 0) && i_wr_ok && (i_wr_addr == i_rd_addr);

  // Forwarded pend is the post-write bit: only a same-cycle reservation keeps it set.
  always_comb begin
    w_data = i_mem[w_idx];
    w_pend = i_pend[w_idx];
    if (!w_in_rng || w_zero) begin
      w_data = '0;
      w_pend = 1'b0;
    end else if (w_fwd) begin
      w_data = i_wr_data;
      w_pend = i_rsv_ok && (i_rsv_addr == i_rd_addr);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_rd_data  <= '0;
      o_rd_pend  <= 1'b0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= w_data;
        o_rd_pend <= w_pend;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parameterised multi-port register file with pending bits and a background
// bulk-clear sweep that zeroes one entry per cycle while reads stay live.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input logic      clk,
  input logic      n_rst,
  regfile_if.slave bus
);

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_pend;
  rf_state_e                    r_state;
  logic [ADDR_W-1:0]            r_idx;
  logic                         r_busy;
  logic                         r_done;

  logic                         w_wr_ok;
  logic                         w_rsv_ok;
  logic [NRD-1:0][DATA_W-1:0]   w_rd_data;
  logic [NRD-1:0]               w_rd_pend;
  logic [NRD-1:0]               w_rd_valid;

  function automatic logic f_addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Control-side updates are frozen while the clear sweep owns the array.
  assign w_wr_ok  = bus.wr_en  && (r_state == RF_IDLE) && f_addr_ok(bus.wr_addr);
  assign w_rsv_ok = bus.rsv_en && (r_state == RF_IDLE) && f_addr_ok(bus.rsv_addr);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mem  <= '0;
      r_pend <= '0;
    end else if (r_state == RF_CLEAR) begin
      r_mem[r_idx]  <= '0;
      r_pend[r_idx] <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[bus.wr_addr]  <= bus.wr_data;
        r_pend[bus.wr_addr] <= 1'b0;
      end
      // Reservation is applied after the write so a same-address pair ends pending.
      if (w_rsv_ok)
        r_pend[bus.rsv_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= RF_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RF_IDLE: begin
          if (bus.clr_start) begin
            r_state <= RF_CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          if (r_idx == LAST_IDX) begin
            r_state <= RF_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= RF_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    regfile_rdport #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_rd_en    (bus.rd_en[gi]),
      .i_rd_addr  (bus.rd_addr[lane_lo(gi, ADDR_W) +: ADDR_W]),
      .i_mem      (r_mem),
      .i_pend     (r_pend),
      .i_wr_ok    (w_wr_ok),
      .i_wr_addr  (bus.wr_addr),
      .i_wr_data  (bus.wr_data),
      .i_rsv_ok   (w_rsv_ok),
      .i_rsv_addr (bus.rsv_addr),
      .o_rd_data  (w_rd_data[gi]),
      .o_rd_pend  (w_rd_pend[gi]),
      .o_rd_valid (w_rd_valid[gi])
    );
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_pend  = w_rd_pend;
  assign bus.rd_valid = w_rd_valid;
  assign bus.clr_busy = r_busy;
  assign bus.clr_done = r_done;

endmodule

// File: tb/tb_regfile_mp.sv
// Two configurations driven in lockstep: A = 16 deep, bypass, no zero reg;
// B = 12 deep, no bypass, hardwired zero register. Both checked every cycle.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        wr_en, rsv_en, clr_start;
  logic [3:0]  wr_addr, rsv_addr;
  logic [15:0] wr_data;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;

  always #5 clk = ~clk;

  regfile_if #(.DATA_W(16), .DEPTH(16), .NRD(2)) ifa ();
  regfile_if #(.DATA_W(16), .DEPTH(12), .NRD(2)) ifb ();

  assign ifa.wr_en = wr_en;   assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifa.rsv_en = rsv_en; assign ifb.rsv_en = rsv_en;
  assign ifa.rsv_addr = rsv_addr; assign ifb.rsv_addr = rsv_addr;
  assign ifa.rd_en = rd_en;   assign ifb.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;
  assign ifa.clr_start = clr_start; assign ifb.clr_start = clr_start;

  regfile_mp #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .NRD(2), .BYPASS(1), .ZERO_REG(0))
    u_a (.clk(clk), .n_rst(n_rst), .bus(ifa.slave));
  regfile_mp #(.DATA_W(16), .DEPTH(12), .ADDR_W(4), .NRD(2), .BYPASS(0), .ZERO_REG(1))
    u_b (.clk(clk), .n_rst(n_rst), .bus(ifb.slave));

  logic [31:0] o_data [2];
  logic [1:0]  o_pend [2];
  logic [1:0]  o_vld  [2];
  logic        o_busy [2];
  logic        o_done [2];
  assign o_data[0] = ifa.rd_data;  assign o_data[1] = ifb.rd_data;
  assign o_pend[0] = ifa.rd_pend;  assign o_pend[1] = ifb.rd_pend;
  assign o_vld[0]  = ifa.rd_valid; assign o_vld[1]  = ifb.rd_valid;
  assign o_busy[0] = ifa.clr_busy; assign o_busy[1] = ifb.clr_busy;
  assign o_done[0] = ifa.clr_done; assign o_done[1] = ifb.clr_done;

  localparam int MD [2] = '{16, 12};
  localparam int MB [2] = '{1, 0};
  localparam int MZ [2] = '{0, 1};

  // Reference model: architectural contents plus a clear sweep position.
  logic [15:0] m_mem  [2][16];
  bit          m_pend [2][16];
  bit          m_busy [2];
  int          m_pos  [2];
  bit          m_done [2];
  logic [15:0] e_data [2][2];
  bit          e_pend [2][2];
  bit          e_vld  [2][2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit addr_ok(input int c, input logic [3:0] a);
    return (int'(a) < MD[c]) && !(MZ[c] != 0 && a == 4'd0);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        m_mem[c][a] = '0;
        m_pend[c][a] = 1'b0;
      end
      m_busy[c] = 1'b0; m_pos[c] = 0; m_done[c] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        e_data[c][p] = '0; e_pend[c][p] = 1'b0; e_vld[c][p] = 1'b0;
      end
    end
  endtask

  task automatic model_eval();
    for (int c = 0; c < 2; c++) begin
      bit wv, rv;
      wv = wr_en  && !m_busy[c] && addr_ok(c, wr_addr);
      rv = rsv_en && !m_busy[c] && addr_ok(c, rsv_addr);
      for (int p = 0; p < 2; p++) begin
        logic [3:0] a;
        a = rd_addr[p*4 +: 4];
        e_vld[c][p] = rd_en[p];
        if (rd_en[p]) begin
          if (!addr_ok(c, a)) begin
            e_data[c][p] = '0; e_pend[c][p] = 1'b0;
          end else if (MB[c] != 0 && wv && wr_addr == a) begin
            e_data[c][p] = wr_data; e_pend[c][p] = rv && (rsv_addr == a);
          end else begin
            e_data[c][p] = m_mem[c][a]; e_pend[c][p] = m_pend[c][a];
          end
        end
      end
      m_done[c] = 1'b0;
      if (m_busy[c]) begin
        m_mem[c][m_pos[c]] = '0;
        m_pend[c][m_pos[c]] = 1'b0;
        m_pos[c]++;
        if (m_pos[c] == MD[c]) begin
          m_busy[c] = 1'b0; m_done[c] = 1'b1;
        end
      end else begin
        if (wv) begin m_mem[c][wr_addr] = wr_data; m_pend[c][wr_addr] = 1'b0; end
        if (rv) m_pend[c][rsv_addr] = 1'b1;
        if (clr_start) begin m_busy[c] = 1'b1; m_pos[c] = 0; end
      end
    end
  endtask

  task automatic check_model();
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("cfg%0d p%0d rd_data", c, p), 32'(o_data[c][p*16 +: 16]), 32'(e_data[c][p]));
        chk($sformatf("cfg%0d p%0d rd_pend", c, p), 32'(o_pend[c][p]), 32'(e_pend[c][p]));
        chk($sformatf("cfg%0d p%0d rd_valid", c, p), 32'(o_vld[c][p]), 32'(e_vld[c][p]));
      end
      chk($sformatf("cfg%0d clr_busy", c), 32'(o_busy[c]), 32'(m_busy[c]));
      chk($sformatf("cfg%0d clr_done", c), 32'(o_done[c]), 32'(m_done[c]));
    end
  endtask

  task automatic idle();
    wr_en = 0; rsv_en = 0; clr_start = 0; rd_en = 2'b00;
    wr_addr = '0; rsv_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic cyc();
    model_eval();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic we; logic [3:0] wa; logic [15:0] wd;
    logic re; logic [3:0] ra;
    logic [1:0] rde; logic [3:0] a0, a1;
    logic [15:0] ad0, ad1; logic [1:0] ap;
    logic [15:0] bd0, bd1; logic [1:0] bp;
    logic [1:0] v;
  } vec_t;

  vec_t vt [14];
  int   busy_cnt [2];
  int   done_cnt [2];

  initial begin
    vt[0]  = '{1,4'd1,16'h0001, 0,4'd0, 2'b00,4'd0,4'd0,  16'h0000,16'h0000,2'b00, 16'h0000,16'h0000,2'b00, 2'b00};
    vt[1]  = '{1,4'd0,16'h0003, 0,4'd0, 2'b00,4'd0,4'd0,  16'h0000,16'h0000,2'b00, 16'h0000,16'h0000,2'b00, 2'b00};
    vt[2]  = '{0,4'd0,16'h0000, 0,4'd0, 2'b11,4'd1,4'd0,  16'h0001,16'h0003,2'b00, 16'h0001,16'h0000,2'b00, 2'b11};
    vt[3]  = '{1,4'd5,16'h00AA, 0,4'd0, 2'b11,4'd5,4'd5,  16'h00AA,16'h00AA,2'b00, 16'h0000,16'h0000,2'b00, 2'b11};
    vt[4]  = '{0,4'd0,16'h0000, 0,4'd0, 2'b11,4'd5,4'd1,  16'h00AA,16'h0001,2'b00, 16'h00AA,16'h0001,2'b00, 2'b11};
    vt[5]  = '{0,4'd0,16'h0000, 1,4'd3, 2'b00,4'd0,4'd0,  16'h00AA,16'h0001,2'b00, 16'h00AA,16'h0001,2'b00, 2'b00};
    vt[6]  = '{0,4'd0,16'h0000, 0,4'd0, 2'b11,4'd3,4'd3,  16'h0000,16'h0000,2'b11, 16'h0000,16'h0000,2'b11, 2'b11};
    vt[7]  = '{1,4'd3,16'h0007, 0,4'd0, 2'b01,4'd3,4'd3,  16'h0007,16'h0000,2'b10, 16'h0000,16'h0000,2'b11, 2'b01};
    vt[8]  = '{0,4'd0,16'h0000, 0,4'd0, 2'b11,4'd3,4'd3,  16'h0007,16'h0007,2'b00, 16'h0007,16'h0007,2'b00, 2'b11};
    vt[9]  = '{1,4'd3,16'h0009, 1,4'd3, 2'b01,4'd3,4'd3,  16'h0009,16'h0007,2'b01, 16'h0007,16'h0007,2'b00, 2'b01};
    vt[10] = '{0,4'd0,16'h0000, 0,4'd0, 2'b10,4'd3,4'd3,  16'h0009,16'h0009,2'b11, 16'h0007,16'h0009,2'b10, 2'b10};
    vt[11] = '{1,4'd0,16'hFFFF, 0,4'd0, 2'b00,4'd0,4'd0,  16'h0009,16'h0009,2'b11, 16'h0007,16'h0009,2'b10, 2'b00};
    vt[12] = '{1,4'd13,16'h5555,0,4'd0, 2'b00,4'd0,4'd0,  16'h0009,16'h0009,2'b11, 16'h0007,16'h0009,2'b10, 2'b00};
    vt[13] = '{0,4'd0,16'h0000, 0,4'd0, 2'b11,4'd0,4'd13, 16'hFFFF,16'h5555,2'b00, 16'h0000,16'h0000,2'b00, 2'b11};

    idle();
    n_rst = 1'b0;
    model_reset();
    #12;
    check_model();
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rsv_en = vt[i].re; rsv_addr = vt[i].ra;
      rd_en = vt[i].rde; rd_addr = {vt[i].a1, vt[i].a0};
      cyc();
      chk($sformatf("vec%0d A data", i), o_data[0], {vt[i].ad1, vt[i].ad0});
      chk($sformatf("vec%0d A pend", i), 32'(o_pend[0]), 32'(vt[i].ap));
      chk($sformatf("vec%0d B data", i), o_data[1], {vt[i].bd1, vt[i].bd0});
      chk($sformatf("vec%0d B pend", i), 32'(o_pend[1]), 32'(vt[i].bp));
      chk($sformatf("vec%0d valid", i), 32'(o_vld[0]), 32'(vt[i].v));
    end
    idle();

    // Fill, then bulk clear with blocked write, live read and ignored restart
    for (int a = 0; a < 16; a++) begin
      wr_en = 1; wr_addr = 4'(a); wr_data = 16'h1234;
      cyc();
    end
    idle();
    clr_start = 1;
    cyc();
    clr_start = 0;
    for (int c = 0; c < 2; c++) begin busy_cnt[c] = int'(o_busy[c]); done_cnt[c] = 0; end
    for (int k = 0; k < 20; k++) begin
      idle();
      if (k == 4) begin
        wr_en = 1; wr_addr = 4'd2; wr_data = 16'hBEEF; rsv_en = 1; rsv_addr = 4'd2;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd15};
      end
      if (k == 6) begin rd_en = 2'b10; rd_addr = {4'd2, 4'd0}; end
      if (k == 8) clr_start = 1;
      cyc();
      if (k == 4) chk("clr mid read15 A", 32'(o_data[0][15:0]), 32'h1234);
      if (k == 6) begin
        chk("clr write blocked A", 32'(o_data[0][31:16]), 32'h0);
        chk("clr rsv blocked A", 32'(o_pend[0][1]), 32'h0);
      end
      for (int c = 0; c < 2; c++) begin
        busy_cnt[c] += int'(o_busy[c]);
        done_cnt[c] += int'(o_done[c]);
      end
    end
    idle();
    chk("clr busy cycles A", 32'(busy_cnt[0]), 32'd16);
    chk("clr busy cycles B", 32'(busy_cnt[1]), 32'd12);
    chk("clr done pulses A", 32'(done_cnt[0]), 32'd1);
    chk("clr done pulses B", 32'(done_cnt[1]), 32'd1);
    for (int a = 0; a < 16; a += 2) begin
      rd_en = 2'b11; rd_addr = {4'(a + 1), 4'(a)};
      cyc();
      chk($sformatf("post clr A @%0d", a), o_data[0], 32'h0);
    end
    idle();

    // Reset in the middle of a clear
    wr_en = 1; wr_addr = 4'd5; wr_data = 16'h00AA;
    cyc();
    idle();
    clr_start = 1;
    cyc();
    clr_start = 0;
    for (int k = 0; k < 6; k++) begin
      rd_en = 2'b11; rd_addr = {4'd5, 4'd5};
      cyc();
    end
    idle();
    chk("pre-reset data A", o_data[0], 32'h00AA00AA);
    #3;
    n_rst = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("async rst cfg%0d data", c), o_data[c], 32'h0);
      chk($sformatf("async rst cfg%0d pend", c), 32'(o_pend[c]), 32'h0);
      chk($sformatf("async rst cfg%0d valid", c), 32'(o_vld[c]), 32'h0);
      chk($sformatf("async rst cfg%0d busy", c), 32'(o_busy[c]), 32'h0);
      chk($sformatf("async rst cfg%0d done", c), 32'(o_done[c]), 32'h0);
    end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    done_cnt[0] = 0; done_cnt[1] = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      done_cnt[0] += int'(o_done[0]);
      done_cnt[1] += int'(o_done[1]);
    end
    chk("no done after abort A", 32'(done_cnt[0]), 32'd0);
    chk("no done after abort B", 32'(done_cnt[1]), 32'd0);
    wr_en = 1; wr_addr = 4'd4; wr_data = 16'h4242;
    cyc();
    idle();
    rd_en = 2'b01; rd_addr = {4'd0, 4'd4};
    cyc();
    chk("roundtrip A", 32'(o_data[0][15:0]), 32'h4242);
    chk("roundtrip B", 32'(o_data[1][15:0]), 32'h4242);
    idle();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      wr_en = ($urandom_range(0, 1) == 1);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 16'($urandom);
      rsv_en = ($urandom_range(0, 3) == 0);
      rsv_addr = ($urandom_range(0, 1) == 1) ? wr_addr : 4'($urandom_range(0, 15));
      rd_en = 2'($urandom_range(0, 3));
      rd_addr = ($urandom_range(0, 2) == 0) ? {wr_addr, wr_addr} : 8'($urandom);
      clr_start = ($urandom_range(0, 49) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the fixed 16×16 two-read-port register file in the datapath. It provides configurable width, depth and read-port count, plus per-port read enables and write-to-read bypass. It adds an optional hardwired zero register, a per-entry pending (scoreboard) bit for the control unit, and a background bulk-clear sequencer. It sits between the control FSM and the ALU in the same place as the current register file.

## Interface
- DATA_W, 16, data word width
- DEPTH, 16, number of registers (≥2, need not be power of 2)
- ADDR_W, $clog2(DEPTH), address width
- NRD, 2, number of read ports (1–4)
- BYPASS, 1, 1 = same-cycle write forwarded to reads
- ZERO_REG, 0, 1 = entry 0 reads 0, writes to it ignored

One clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  mark entry pending
- rsv_addr  in  ADDR_W  entry to mark
- rd_en  in  NRD  per-port read strobe
- rd_addr  in  NRD*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  port i at [i*DATA_W +: DATA_W]
- rd_pend  out  NRD  pending bit of the entry read on port i
- rd_valid  out  NRD  port i data updated this cycle
- clr_start  in  1  begin bulk clear
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse at clear end

## Operation
- Write: wr_en=1 stores wr_data at wr_addr and clears that entry's pending bit.
- Reservation: rsv_en=1 sets the pending bit of rsv_addr. If wr_en and rsv_en hit the same address in one cycle, the data is stored and the pending bit ends set.
- Read: rd_en[i]=1 registers the entry's data and pending bit into port i. Without rd_en[i], rd_data/rd_pend hold their previous values.
- BYPASS=1: a same-cycle write to the read address returns wr_data. rd_pend then returns the post-update bit, which is 1 only if a same-cycle rsv targets that address.
- BYPASS=0: reads return the pre-write data and pre-update pending bit.
- ZERO_REG=1: entry 0 always reads data 0 with pend 0. Writes and reservations to entry 0 are ignored.
- Address ≥ DEPTH: the write or reservation is ignored; the read returns data 0 and pend 0.
- Multiple ports may read the same address in one cycle; each returns identical data.
- Clear FSM states:
  - RF_IDLE → RF_CLEAR on clr_start.
  - In RF_CLEAR, an index walks 0..DEPTH-1, zeroing one entry and its pending bit per cycle.
  - At index DEPTH-1, RF_CLEAR → RF_IDLE.
- During RF_CLEAR:
  - wr_en, rsv_en and clr_start are ignored.
  - Reads are permitted and return current contents: already-cleared entries read 0.
  - clr_busy=1.

## Timing
- Read latency is 1 cycle: rd_data, rd_pend and rd_valid are visible the cycle after rd_en.
- rd_valid[i] is a registered copy of rd_en[i].
- A write is visible to non-bypassed reads issued in the following cycle.
- Clear takes exactly DEPTH cycles.
  - clr_busy is high from the cycle after clr_start for DEPTH cycles.
  - clr_done pulses in the cycle after the last entry is zeroed, when clr_busy has dropped.
- Reset values, taking effect immediately on n_rst=0:
  - all entries and pending bits 0
  - rd_data 0, rd_pend 0, rd_valid 0
  - clr_busy 0, clr_done 0
  - state RF_IDLE, clear index 0
- Reset mid-clear aborts the clear with no clr_done pulse.

## Structure
- Package regfile_pkg holds:
  - typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e
  - a localparam function for lane slicing helpers
- Sub-module regfile_rdport implements one read lane: address range and zero check, bypass mux, output registers. It is instantiated NRD times in a generate loop.
- Storage, the pending vector and the clear FSM stay in regfile_mp.

## Test plan
- Reset, then write 0x0001@1 and 0x0003@0, then read port0=1, port1=0 → after 1 cycle rd_data 0x0001/0x0003, rd_valid=2'b11.
- Same-cycle write 0x00AA@5 with port0 reading 5: BYPASS=1 → 0x00AA; BYPASS=0 → previous value 0x0000.
- rsv@3, read 3 → rd_pend=1; write 0x0007@3, then read 3 → rd_pend=0, data 0x0007; wr+rsv same cycle @3 → rd_pend=1.
- ZERO_REG=1: write 0xFFFF@0, read 0 → 0x0000. DEPTH=12: write@13 is ignored, read@13 → 0.
- Fill all entries with 0x1234, pulse clr_start → clr_busy high for 16 cycles and writes ignored; read 15 mid-clear → 0x1234; clr_done pulses; all reads then 0.
- Assert n_rst low at clear index 6 → all outputs 0 immediately, no clr_done; after release a write/read round-trip works.
